matrix_inverse: RTL and testbench
=================================

// Module: matrix_inverse
// PURPOSE
//   Sequential 3x3 signed-integer matrix inverter with fixed-point output.
//   On start: computes determinant and adjugate, then inv = adj/det element by element.
//   Uses one shared restoring divider; results are signed fixed-point with FW fraction bits.
//   Standalone compute block: fed by a controller or host register file, result read after done.
// PARAMETERS
//   DW   16  signed input element width
//   FW   16  fraction bits of each output element (1.0 = 2**FW)
//   derived (localparam): DETW = 3*DW+3 (det width); OW = 2*DW+FW+1 (output element width)
// PORTS
//   clk      in   1       rising-edge clock
//   rst_n    in   1       synchronous, active-low reset
//   start    in   1       request; accepted only in IDLE
//   a_in     in   9*DW    signed matrix, row-major; element [i][j] at bits (3*i+j)*DW +: DW
//   busy     out  1       high from the cycle after acceptance until done
//   done     out  1       one-cycle pulse when results are valid
//   singular out  1       det==0 for the last completed operation
//   det_out  out  DETW    signed determinant of the last operation
//   inv_out  out  9*OW    signed inverse, row-major, same packing as a_in
// BEHAVIOUR
//   Reset: busy=0, done=0, singular=0, det_out=0, inv_out=0, FSM=IDLE.
//   Reset mid-operation aborts; all outputs take their reset values on the next edge.
//   FSM states:
//   - IDLE: start=1 at edge T latches a_in and moves to CALC.
//   - CALC (1 cycle): registers the 9 cofactors (adj = transpose of cofactor matrix) and det.
//     det==0 goes to DONE; otherwise goes to DIV.
//   - DIV: 9 divisions, index 0..8 row-major; each division is 1 load cycle plus OW iterations.
//   - DONE (1 cycle): done=1, then returns to IDLE.
//   Latency, nonsingular: done is high in cycle T+2+9*(OW+1) (T+452 at defaults).
//   Latency, singular: done is high in cycle T+2.
//   Division: q = (|adj| << FW) / |det|, truncated (toward zero).
//     Sign is sign(adj) XOR sign(det); a zero quotient stays 0.
//   Singular result: inv_out all zero, singular=1; det_out=0 is still written.
//   Writes: det_out is written in CALC; inv_out elements are written as each quotient finishes.
//     singular is written when leaving CALC.
//   Outputs hold their values until the next accepted start.
//   start while busy (CALC/DIV/DONE) is ignored; it is neither queued nor restarted.
//   Arithmetic: all multiplies and sums are signed, sized to DETW/OW with no overflow;
//     OW is wide enough that saturation never occurs.
// STRUCTURE
//   Package matrix_inverse_pkg: DW/FW defaults, DETW/OW width functions, FSM state enum.
//   Sub-module udiv_restoring: unsigned, 1 quotient bit per cycle, WIDTH parameter;
//     ports load/dividend/divisor/quotient/valid.
//   Top holds the FSM, cofactor/det datapath and sign handling.
// TESTING (defaults DW=16, FW=16)
//   Identity: inv diagonal = 65536, off-diagonal = 0; det=1; done exactly at T+452.
//   diag(2,4,-8): inv diagonal = 32768, 16384, -8192; det=-64; singular=0.
//   [[1,2,0],[0,1,0],[0,0,1]]: inv[0][1] = -131072, diagonal = 65536; det=1.
//   diag(3,1,1): inv[0][0] = 21845 (truncated), others 65536 / 0.
//   [[1,2,3],[4,5,6],[7,8,9]]: det=0, singular=1, inv_out all 0, done at T+2.
//   start pulsed during DIV: ignored, single done.
//   rst_n=0 at T+100: busy=0 and done=0 on the next edge.

Source files
------------

// File: rtl/matrix_inverse_pkg.sv
// Shared definitions for the 3x3 matrix inverter: default element/fraction
// widths, derived width helpers and the controller state encoding.
package matrix_inverse_pkg;

  localparam int DW_DEF = 16;
  localparam int FW_DEF = 16;

  // Signed determinant width: three DW x (2*DW+1) products plus two carries.
  function automatic int detw(input int dw);
    return 3 * dw + 3;
  endfunction

  // Signed output element width: |adj| << FW plus a sign bit.
  function automatic int ow(input int dw, input int fw);
    return 2 * dw + fw + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DIV,
    ST_DONE
  } state_e;

endpackage

// File: rtl/matrix_inverse_udiv_restoring.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   load        captures dividend/divisor and starts WIDTH iterations
//   dividend    WIDTH-bit unsigned numerator
//   divisor     DVW-bit unsigned denominator (must be non-zero)
//   quotient    WIDTH-bit result, final once valid pulses
//   valid       one-cycle pulse the cycle after the last iteration
module udiv_restoring #(
  parameter int WIDTH = 49,
  parameter int DVW   = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [DVW-1:0]   divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             valid
);

  localparam int CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_q;
  logic [DVW-1:0]   rem_q;
  logic [DVW-1:0]   dvs_q;
  logic [CNTW-1:0]  cnt_q;
  logic             valid_q;

  logic [DVW:0]     rem_sh;
  logic [DVW-1:0]   rem_sub;
  logic             fits;

  // The shifted remainder is one bit wider than the divisor; when it fits,
  // the true difference is below the divisor, so DVW bits are enough.
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, dvs_q});
    rem_sub = rem_sh[DVW-1:0] - dvs_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      quo_q   <= dividend;
      rem_q   <= '0;
      dvs_q   <= divisor;
      cnt_q   <= CNTW'(WIDTH);
      valid_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q   <= fits ? rem_sub : rem_sh[DVW-1:0];
      quo_q   <= {quo_q[WIDTH-2:0], fits};
      cnt_q   <= cnt_q - CNTW'(1);
      valid_q <= (cnt_q == CNTW'(1));
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign quotient = quo_q;
  assign valid    = valid_q;

endmodule

// File: rtl/matrix_inverse.sv
// Sequential 3x3 signed-integer matrix inverter with fixed-point output.
// Computes det and adjugate in one cycle, then divides each adjugate element
// by det with a shared restoring divider (FW fraction bits).
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       request, accepted only when idle
//   a_in        9 signed DW elements, row-major, [i][j] at (3*i+j)*DW
//   busy        high from the cycle after acceptance until done
//   done        one-cycle pulse when results are valid
//   singular    det == 0 for the last completed operation
//   det_out     signed determinant (DETW bits)
//   inv_out     9 signed OW-bit elements, same packing as a_in
//
// state   | meaning
// IDLE    | waiting for start; outputs hold last results
// CALC    | register cofactors/det; skip division when det == 0
// DIV     | 9 divisions, each 1 load cycle + OW iterations
// DONE    | pulse done, last quotient lands here, return to IDLE
module matrix_inverse
  import matrix_inverse_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [9*DW-1:0]         a_in,
  output logic                    busy,
  output logic                    done,
  output logic                    singular,
  output logic [detw(DW)-1:0]     det_out,
  output logic [9*ow(DW, FW)-1:0] inv_out
);

  localparam int DETW = detw(DW);
  localparam int OW   = ow(DW, FW);
  localparam int CW   = 2 * DW + 1;
  localparam int TW   = $clog2(OW + 1);

  state_e                 state_q;
  logic [9*DW-1:0]        a_q;
  logic signed [CW-1:0]   cof_q [9];
  logic signed [DETW-1:0] det_q;
  logic [9*OW-1:0]        inv_q;
  logic                   busy_q, done_q, sing_q;
  logic [3:0]             idx_q, wr_idx_q;
  logic [TW-1:0]          tmr_q;

  logic signed [DETW-1:0] a_x   [9];
  logic signed [CW-1:0]   adj_c [9];
  logic signed [DETW-1:0] det_c;

  // Products are formed at DETW and truncated; the true values always fit,
  // so modular arithmetic gives exact results.
  always_comb begin
    for (int k = 0; k < 9; k++) a_x[k] = DETW'(signed'(a_q[k*DW +: DW]));
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        adj_c[3*i+j] = CW'(a_x[3*((j+1)%3) + (i+1)%3] * a_x[3*((j+2)%3) + (i+2)%3]
                         - a_x[3*((j+1)%3) + (i+2)%3] * a_x[3*((j+2)%3) + (i+1)%3]);
      end
    end
    det_c = a_x[0] * DETW'(adj_c[0]) + a_x[1] * DETW'(adj_c[3]) + a_x[2] * DETW'(adj_c[6]);
  end

  logic                   div_load, div_valid;
  logic signed [CW-1:0]   adj_sel;
  logic [CW-1:0]          adj_mag;
  logic [DETW-1:0]        det_mag;
  logic [OW-1:0]          div_quo;
  logic [OW-1:0]          quo_signed;

  always_comb begin
    adj_sel    = cof_q[idx_q];
    adj_mag    = adj_sel[CW-1] ? CW'(-adj_sel) : CW'(adj_sel);
    det_mag    = det_q[DETW-1] ? DETW'(-det_q) : DETW'(det_q);
    div_load   = (state_q == ST_DIV) && (tmr_q == '0);
    // Negating a zero quotient yields zero, so no special case is needed.
    quo_signed = (cof_q[wr_idx_q][CW-1] ^ det_q[DETW-1]) ? (-div_quo) : div_quo;
  end

  udiv_restoring #(
    .WIDTH(OW),
    .DVW  (DETW)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (div_load),
    .dividend({adj_mag, {FW{1'b0}}}),
    .divisor (det_mag),
    .quotient(div_quo),
    .valid   (div_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      for (int k = 0; k < 9; k++) cof_q[k] <= '0;
      det_q    <= '0;
      inv_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sing_q   <= 1'b0;
      idx_q    <= '0;
      wr_idx_q <= '0;
      tmr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      // A quotient is retired while the next division loads (or in DONE).
      if (div_valid) inv_q[wr_idx_q*OW +: OW] <= quo_signed;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          for (int k = 0; k < 9; k++) cof_q[k] <= adj_c[k];
          det_q  <= det_c;
          sing_q <= (det_c == '0);
          idx_q  <= '0;
          tmr_q  <= '0;
          if (det_c == '0) begin
            inv_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (tmr_q == '0) begin
            tmr_q    <= TW'(OW);
            wr_idx_q <= idx_q;
          end else begin
            tmr_q <= tmr_q - TW'(1);
            if (tmr_q == TW'(1)) begin
              if (idx_q == 4'd8) state_q <= ST_DONE;
              else               idx_q   <= idx_q + 4'd1;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign singular = sing_q;
  assign det_out  = det_q;
  assign inv_out  = inv_q;

endmodule

// File: tb/tb_matrix_inverse.sv
module tb_matrix_inverse;

  localparam int DW     = 16;
  localparam int FW     = 16;
  localparam int OW     = 2*DW + FW + 1;
  localparam int DETW   = 3*DW + 3;
  localparam int NS_LAT = 2 + 9*(OW + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [9*DW-1:0]   a_in;
  logic              busy, done, singular;
  logic [DETW-1:0]   det_out;
  logic [9*OW-1:0]   inv_out;

  matrix_inverse #(.DW(DW), .FW(FW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .busy    (busy),
    .done    (done),
    .singular(singular),
    .det_out (det_out),
    .inv_out (inv_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     checks = 0;
  int     failures = 0;
  int     t_acc = 0;
  int     e_lat = 0;
  int     rst_at = 1;
  int     done_cyc = -1;
  int     done_cnt = 0;
  bit     active = 1'b0;
  longint e_det;
  bit     e_sing;
  longint e_inv [9];
  longint mm [3][3];
  int     mat [9];

  task automatic chk(input string nm, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, expv);
    end
  endtask

  function automatic longint dut_inv(input int k);
    logic [OW-1:0] e;
    e = inv_out[k*OW +: OW];
    return longint'(signed'(e));
  endfunction

  function automatic longint dut_det();
    return longint'(signed'(det_out));
  endfunction

  function automatic longint minor2(input int r, input int c);
    int rr [2];
    int cc [2];
    int nr = 0;
    int nc = 0;
    for (int i = 0; i < 3; i++) begin
      if (i != r) begin rr[nr] = i; nr++; end
      if (i != c) begin cc[nc] = i; nc++; end
    end
    return mm[rr[0]][cc[0]] * mm[rr[1]][cc[1]] - mm[rr[0]][cc[1]] * mm[rr[1]][cc[0]];
  endfunction

  // Reference: Laplace expansion for det, adj = transpose of cofactors,
  // then truncated (|adj| * 2^FW) / |det| with the product sign.
  task automatic build_model();
    longint adj, mag, sgn;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) mm[i][j] = mat[3*i+j];
    e_det = 0;
    for (int j = 0; j < 3; j++) begin
      sgn = (j % 2) ? -1 : 1;
      e_det += sgn * mm[0][j] * minor2(0, j);
    end
    e_sing = (e_det == 0);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        sgn = ((i + j) % 2) ? -1 : 1;
        adj = sgn * minor2(j, i);
        if (e_sing) begin
          e_inv[3*i+j] = 0;
        end else begin
          mag = ((adj < 0 ? -adj : adj) * (longint'(1) << FW)) / (e_det < 0 ? -e_det : e_det);
          e_inv[3*i+j] = ((adj < 0) != (e_det < 0)) ? -mag : mag;
        end
      end
    end
    e_lat = e_sing ? 2 : NS_LAT;
  endtask

  // Single compare process: busy/done every cycle, data from done onward,
  // and reset values while a reset is in effect.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        done_cnt++;
      end
      if (rst_at >= 0 && cyc >= rst_at) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_singular", singular, 0);
        chk("rst_det", dut_det(), 0);
        for (int k = 0; k < 9; k++) chk($sformatf("rst_inv%0d", k), dut_inv(k), 0);
      end else if (active) begin
        chk("busy", busy, longint'(cyc >= t_acc && cyc < t_acc + e_lat));
        chk("done", done, longint'(cyc == t_acc + e_lat));
        if (cyc >= t_acc + e_lat) begin
          chk("det", dut_det(), e_det);
          chk("singular", singular, longint'(e_sing));
          for (int k = 0; k < 9; k++) chk($sformatf("inv%0d", k), dut_inv(k), e_inv[k]);
        end
      end
    end
  end

  task automatic run_op(input int pulse_off, input int rst_off);
    @(negedge clk);
    for (int k = 0; k < 9; k++) a_in[k*DW +: DW] = DW'(mat[k]);
    build_model();
    start    = 1'b1;
    t_acc    = cyc + 1;
    rst_at   = -1;
    done_cnt = 0;
    active   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t_acc + e_lat + 3) begin
      @(negedge clk);
      if (pulse_off > 0 && cyc == t_acc + pulse_off - 1) begin
        start = 1'b1;
        a_in  = {9{16'sd7}};
      end else begin
        start = 1'b0;
      end
      if (rst_off > 0 && cyc == t_acc + rst_off - 1) begin
        rst_n  = 1'b0;
        rst_at = cyc + 1;
        active = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mat = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    run_op(0, 0);
    chk("id_inv00", dut_inv(0), 65536);
    chk("id_inv01", dut_inv(1), 0);
    chk("id_inv22", dut_inv(8), 65536);
    chk("id_det", dut_det(), 1);
    chk("id_latency", done_cyc - t_acc, 452);

    mat = '{2, 0, 0, 0, 4, 0, 0, 0, -8};
    run_op(0, 0);
    chk("diag_inv00", dut_inv(0), 32768);
    chk("diag_inv11", dut_inv(4), 16384);
    chk("diag_inv22", dut_inv(8), -8192);
    chk("diag_det", dut_det(), -64);
    chk("diag_singular", singular, 0);

    mat = '{1, 2, 0, 0, 1, 0, 0, 0, 1};
    run_op(0, 0);
    chk("shear_inv01", dut_inv(1), -131072);
    chk("shear_inv11", dut_inv(4), 65536);
    chk("shear_det", dut_det(), 1);

    mat = '{3, 0, 0, 0, 1, 0, 0, 0, 1};
    run_op(0, 0);
    chk("trunc_inv00", dut_inv(0), 21845);
    chk("trunc_inv11", dut_inv(4), 65536);
    chk("trunc_inv01", dut_inv(1), 0);

    mat = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_op(0, 0);
    chk("sing_flag", singular, 1);
    chk("sing_det", dut_det(), 0);
    chk("sing_inv00", dut_inv(0), 0);
    chk("sing_latency", done_cyc - t_acc, 2);

    mat = '{2, -1, 0, -1, 2, -1, 0, -1, 2};
    run_op(60, 0);
    chk("pulse_single_done", done_cnt, 1);
    chk("pulse_det", dut_det(), 4);

    mat = '{1, 2, 3, 0, 1, 4, 5, 6, 0};
    run_op(0, 100);
    repeat (3) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done_cnt", done_cnt, 0);

    mat = '{4, 7, 2, 3, 6, 1, 2, 5, 3};
    run_op(0, 0);
    chk("recover_det", dut_det(), 9);
    chk("recover_inv00", dut_inv(0), 94663);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
